// File: rtl/vga_bcd_score_display_pkg.sv
// vga_bcd_score_display_pkg: shared screen, glyph and BCD constants for the score overlay
package vga_bcd_score_display_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 5;
  localparam int CELL_LOG2 = 3;
  localparam int BCD_W = 4;
endpackage

// File: rtl/vga_bcd_score_display_glyph_rom.sv
// digit_glyph_rom: combinational 5x5 font for decimal digits, bit 4 is the leftmost column
module digit_glyph_rom
  import vga_bcd_score_display_pkg::*;
(
  input  logic [BCD_W-1:0]   digit,
  input  logic [2:0]         row,
  output logic [GLYPH_W-1:0] bits
);
  logic [GLYPH_W*GLYPH_H-1:0] g;
  always_comb begin
    case (digit)
      4'd0:    g = 25'b11111_10001_10001_10001_11111;
      4'd1:    g = 25'b00100_01100_00100_00100_01110;
      4'd2:    g = 25'b11111_00001_11111_10000_11111;
      4'd3:    g = 25'b11111_00001_01111_00001_11111;
      4'd4:    g = 25'b10001_10001_11111_00001_00001;
      4'd5:    g = 25'b11111_10000_11111_00001_11111;
      4'd6:    g = 25'b11111_10000_11111_10001_11111;
      4'd7:    g = 25'b11111_00001_00010_00100_01000;
      4'd8:    g = 25'b11111_10001_11111_10001_11111;
      4'd9:    g = 25'b11111_10001_11111_00001_11111;
      default: g = '0;
    endcase
    bits = row == 3'd0 ? g[24:20] :
           row == 3'd1 ? g[19:15] :
           row == 3'd2 ? g[14:10] :
           row == 3'd3 ? g[9:5]   :
           row == 3'd4 ? g[4:0]   : '0;
  end
endmodule

// File: rtl/vga_bcd_score_display.sv
// vga_bcd_score_display: BCD score counter with frame-latched, scaled glyph overlay
// and a 2-stage pixel pipeline aligned to de_out.
module vga_bcd_score_display
  import vga_bcd_score_display_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int SCALE   = 2,
  parameter int X0      = 64,
  parameter int Y0      = 32,
  parameter int LZB     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     frame_start,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     display_on,
  output logic [BCD_W*NDIGITS-1:0] count,
  output logic                     overflow,
  output logic                     pixel_on,
  output logic                     de_out
);
  localparam int SH   = CELL_LOG2 + SCALE;
  localparam int CELL = 1 << SH;
  localparam int W    = BCD_W * NDIGITS;

  logic [W-1:0]       count_q, count_d, shown_q;
  logic               overflow_q, overflow_d;
  logic [NDIGITS:0]   carry, lz;
  logic [NDIGITS-1:0] blank_v;
  logic signed [10:0] dx, dy;
  logic               in_win, sel_blank;
  logic [2:0]         idx, col, row;
  logic [BCD_W-1:0]   sel_dig, dig_q;
  logic               win_q, blank_q, de1_q, pix_q, pix_d, de2_q;
  logic [2:0]         col_q, row_q;
  logic [GLYPH_W-1:0] rom_bits;
  logic [7:0]         rom_pad;

  assign carry[0]   = inc;
  assign lz[NDIGITS] = 1'b1;

  // carry ripples from digit 0 upward; lz tracks "this and all higher shown digits are zero"
  genvar i;
  for (i = 0; i < NDIGITS; i++) begin : g_dig
    logic [BCD_W-1:0] cur, shn;
    assign cur = count_q[BCD_W*i +: BCD_W];
    assign shn = shown_q[BCD_W*i +: BCD_W];
    assign carry[i+1] = carry[i] & (cur == 4'd9);
    assign count_d[BCD_W*i +: BCD_W] = clr ? '0 : ~carry[i] ? cur : cur == 4'd9 ? '0 : cur + 4'd1;
    assign lz[i] = lz[i+1] & (shn == '0);
    assign blank_v[i] = (LZB != 0) && (i != 0) && lz[i];
  end

  assign overflow_d = ~clr & (overflow_q | carry[NDIGITS]);

  assign dx     = 11'(hpos) - 11'(X0);
  assign dy     = 11'(vpos) - 11'(Y0);
  assign in_win = dx >= 0 && dx < $signed(11'(NDIGITS * CELL)) && dy >= 0 && dy < $signed(11'(CELL));
  assign idx    = 3'(dx >>> SH);
  assign col    = dx[SH-1 -: 3];
  assign row    = dy[SH-1 -: 3];

  // cell index 0 is the most significant digit
  always_comb begin
    sel_dig   = '0;
    sel_blank = 1'b0;
    for (int k = 0; k < NDIGITS; k++)
      if (int'(idx) == NDIGITS - 1 - k) begin
        sel_dig   = shown_q[BCD_W*k +: BCD_W];
        sel_blank = blank_v[k];
      end
  end

  digit_glyph_rom u_rom (
    .digit(dig_q),
    .row  (row_q),
    .bits (rom_bits)
  );

  assign rom_pad = {rom_bits, 3'b000};
  assign pix_d   = win_q & de1_q & ~blank_q & (col_q < 3'(GLYPH_W)) & (row_q < 3'(GLYPH_H))
                 & rom_pad[3'd7 - col_q];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      shown_q    <= '0;
      win_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      dig_q      <= '0;
      blank_q    <= 1'b0;
      de1_q      <= 1'b0;
      pix_q      <= 1'b0;
      de2_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (frame_start) shown_q <= count_q;
      win_q      <= in_win;
      col_q      <= col;
      row_q      <= row;
      dig_q      <= sel_dig;
      blank_q    <= sel_blank;
      de1_q      <= display_on;
      pix_q      <= pix_d;
      de2_q      <= de1_q;
    end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign pixel_on = pix_q;
  assign de_out   = de2_q;
endmodule

// File: tb/tb_vga_bcd_score_display.sv
// tb_vga_bcd_score_display: random/directed stimulus, decimal reference model and
// a queue scoreboard checked by an independent monitor; LZB=1 and LZB=0 instances.
module tb_vga_bcd_score_display;
  localparam int ND = 4, X0 = 64, Y0 = 32, CELL = 32;

  logic clk = 1'b0, reset = 1'b1, inc = 1'b0, clr = 1'b0, frame_start = 1'b0, display_on = 1'b0;
  logic [9:0] hpos = '0, vpos = '0;
  logic [15:0] count, count0;
  logic overflow, overflow0, pixel_on, pixel_on0, de_out, de_out0;

  vga_bcd_score_display #(.NDIGITS(ND), .SCALE(2), .X0(X0), .Y0(Y0), .LZB(1)) dut (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr), .frame_start(frame_start),
    .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .count(count), .overflow(overflow), .pixel_on(pixel_on), .de_out(de_out));

  vga_bcd_score_display #(.NDIGITS(ND), .SCALE(2), .X0(X0), .Y0(Y0), .LZB(0)) dut0 (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr), .frame_start(frame_start),
    .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .count(count0), .overflow(overflow0), .pixel_on(pixel_on0), .de_out(de_out0));

  always #20 clk = ~clk;

  typedef struct { int due; logic [15:0] cnt; logic ovf; } cexp_t;
  typedef struct { int due; logic de; logic pix; logic pix0; } pexp_t;
  cexp_t cq[$];
  pexp_t pq[$];

  int cyc = 0, vectors = 0, errors = 0;
  int count_m = 0, shown_m = 0;
  bit ovf_m = 0;

  logic [24:0] font [10] = '{
    25'b11111_10001_10001_10001_11111, 25'b00100_01100_00100_00100_01110,
    25'b11111_00001_11111_10000_11111, 25'b11111_00001_01111_00001_11111,
    25'b10001_10001_11111_00001_00001, 25'b11111_10000_11111_00001_11111,
    25'b11111_10000_11111_10001_11111, 25'b11111_00001_00010_00100_01000,
    25'b11111_10001_11111_10001_11111, 25'b11111_10001_11111_00001_11111};

  always @(posedge clk) cyc++;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int j = 0; j < ND; j++) begin
      r[4*j +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit model_pix(int x, int y, bit de, int sh, bit lzb);
    int p, pw, d, gx, gy;
    if (!de || x < X0 || x >= X0 + ND*CELL || y < Y0 || y >= Y0 + CELL) return 0;
    p  = ND - 1 - (x - X0) / CELL;
    pw = 1;
    for (int j = 0; j < p; j++) pw *= 10;
    if (lzb && p > 0 && sh < pw) return 0;
    d  = (sh / pw) % 10;
    gx = ((x - X0) % CELL) / (CELL/8);
    gy = ((y - Y0) % CELL) / (CELL/8);
    if (gx > 4 || gy > 4) return 0;
    return font[d][24 - 5*gy - gx];
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step(bit i_inc, bit i_clr, bit i_fs, int h, int v, bit de);
    cexp_t c;
    pexp_t p;
    @(posedge clk); #1;
    inc = i_inc; clr = i_clr; frame_start = i_fs;
    hpos = 10'(h); vpos = 10'(v); display_on = de;
    p.due = cyc + 2; p.de = de;
    p.pix = model_pix(h, v, de, shown_m, 1);
    p.pix0 = model_pix(h, v, de, shown_m, 0);
    pq.push_back(p);
    if (i_fs) shown_m = count_m;
    if (i_clr) begin count_m = 0; ovf_m = 0; end
    else if (i_inc) begin
      if (count_m == 9999) begin count_m = 0; ovf_m = 1; end
      else count_m++;
    end
    c.due = cyc + 1; c.cnt = to_bcd(count_m); c.ovf = ovf_m;
    cq.push_back(c);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic scan(bit de);
    for (int y = Y0 - 2; y <= Y0 + CELL; y++)
      for (int x = X0 - 4; x <= X0 + ND*CELL + 3; x++) step(0, 0, 0, x, y, de);
  endtask

  task automatic set_shown(int n);
    step(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < n; j++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    cexp_t c;
    pexp_t p;
    if (!reset) begin
      while (cq.size() > 0 && cq[0].due <= cyc) begin
        c = cq.pop_front();
        vectors++;
        if (c.due != cyc || count !== c.cnt || overflow !== c.ovf || count0 !== c.cnt) begin
          errors++;
          $display("FAIL count @%0d: got %h/%b (lzb0 %h) want %h/%b", cyc, count, overflow, count0, c.cnt, c.ovf);
        end
      end
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        p = pq.pop_front();
        vectors++;
        if (p.due != cyc || de_out !== p.de || de_out0 !== p.de || pixel_on !== p.pix || pixel_on0 !== p.pix0) begin
          errors++;
          $display("FAIL pixel @%0d h=%0d v=%0d: got de=%b/%b pix=%b pix0=%b want de=%b pix=%b pix0=%b",
                   cyc, hpos, vpos, de_out, de_out0, pixel_on, pixel_on0, p.de, p.pix, p.pix0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", 32'(count), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset pixel_on", 32'({pixel_on, pixel_on0}), 0);
    chk("reset de_out", 32'({de_out, de_out0}), 0);
    reset = 1'b0;

    for (int j = 0; j < 9999; j++) step(1, 0, 0, $urandom_range(40, 230), $urandom_range(20, 80), 1'($urandom));
    idle();
    @(negedge clk);
    chk("count at 9999", 32'(count), 32'h9999);
    chk("overflow at 9999", 32'(overflow), 0);
    step(1, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("count wrap", 32'(count), 0);
    chk("overflow wrap", 32'(overflow), 1);

    step(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < 129; j++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("inc+clr count", 32'(count), 0);
    chk("inc+clr overflow", 32'(overflow), 0);
    for (int j = 0; j < 42; j++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("inc+frame_start count", 32'(count), 32'h0043);
    scan(1);

    set_shown(7);
    scan(1);
    scan(0);

    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
             $urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom));
      else
        step(1'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
             $urandom_range(X0 - 8, X0 + ND*CELL + 8), $urandom_range(Y0 - 4, Y0 + CELL + 4), $urandom_range(0, 7) != 0);
    end

    set_shown(7);
    repeat (3) step(0, 0, 0, 160, 32, 1);
    @(negedge clk);
    chk("lit before reset", 32'(pixel_on), 1);
    #2;
    reset = 1'b1;
    inc = 0; clr = 0; frame_start = 0;
    #1;
    chk("async reset pixel_on", 32'({pixel_on, pixel_on0}), 0);
    chk("async reset de_out", 32'({de_out, de_out0}), 0);
    chk("async reset count", 32'(count), 0);
    cq.delete();
    pq.delete();
    count_m = 0; shown_m = 0; ovf_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    scan(1);

    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(cq.size() + pq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
